core_launcher: RTL

Host-side initiator for the processor core's `req`/`done` run handshake. On a host `start` it holds the core in reset, pulses `req`, and counts execution cycles until the core raises `done` or a timeout expires. It then streams a fixed result window of data memory out through a valid/ready port. It sits between the test/host harness and the core top level, and owns the core's `reset` and `req` inputs plus a read port into data memory.

---
 rtl/core_launcher.sv | 81 ++++++++
 1 files changed

// File: rtl/core_launcher.sv
// core_launcher: resets and launches the core, times its run, then streams a result window of data memory
module core_launcher #(
    parameter int AW       = 8,
    parameter int CW       = 16,
    parameter int RST_CYC  = 2,
    parameter int TIMEOUT  = 4000,
    parameter int RES_BASE = 0,
    parameter int RES_LEN  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          core_rst,
    output logic          req,
    input  logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_dat,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_cnt
);
    localparam logic [2:0] IDLE = 3'd0, CRST = 3'd1, REQ = 3'd2, RUN = 3'd3, DUMP = 3'd4, FIN = 3'd5;
    localparam int IW = $clog2(RES_LEN) + 1;
    localparam int RW = $clog2(RST_CYC) + 1;
    logic [2:0]    st;
    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx;
    // sequencer: launch, run timing with timeout, and result dump indexing
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            rcnt      <= '0;
            idx       <= '0;
            timed_out <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (st)
                IDLE, FIN: if (start) begin
                    st        <= CRST;
                    rcnt      <= RW'(RST_CYC - 1);
                    idx       <= '0;
                    timed_out <= 1'b0;
                    cycle_cnt <= '0;
                end
                CRST: begin
                    rcnt <= rcnt - RW'(1);
                    if (rcnt == '0) st <= REQ;
                end
                REQ: st <= RUN;
                RUN: if (done) begin
                    st  <= DUMP;
                    idx <= '0;
                end else if (cycle_cnt == CW'(TIMEOUT - 1)) begin
                    st        <= FIN;
                    timed_out <= 1'b1;
                end else begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                end
                DUMP: if (out_ready) begin
                    if (idx == IW'(RES_LEN - 1)) st <= FIN;
                    else idx <= idx + IW'(1);
                end
                default: st <= IDLE;
            endcase
        end
    end
    // outputs decoded from state; memory data passes straight through
    always_comb begin
        core_rst  = st == CRST;
        req       = st == REQ;
        out_valid = st == DUMP;
        busy      = !(st == IDLE || st == FIN);
        finished  = st == FIN;
        mem_addr  = st == DUMP ? AW'(RES_BASE) + AW'(idx) : AW'(RES_BASE);
        out_data  = mem_dat;
    end
endmodule
